// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - two-master / two-slave bus fabric with parked arbiter and registered read return
module bus_interconnect #(
   parameter logic [7:0] S0_BASE = 8'h00,
   parameter logic [7:0] S0_LAST = 8'h1F,
   parameter logic [7:0] S1_BASE = 8'h70,
   parameter logic [7:0] S1_LAST = 8'h7F
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        M0_req,
   input  logic        M0_wr,
   input  logic [7:0]  M0_address,
   input  logic [31:0] M0_dout,
   output logic        M0_grant,
   input  logic        M1_req,
   input  logic        M1_wr,
   input  logic [7:0]  M1_address,
   input  logic [31:0] M1_dout,
   output logic        M1_grant,
   output logic [31:0] M_din,
   output logic        S0_sel,
   output logic        S1_sel,
   output logic        S_wr,
   output logic [7:0]  S_address,
   output logic [31:0] S_din,
   input  logic [31:0] S0_dout,
   input  logic [31:0] S1_dout
);

   typedef enum logic {GNT_M0 = 1'b0, GNT_M1 = 1'b1} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        req_g;
   logic [7:0]  s0_off;
   logic [7:0]  s1_off;
   logic        s0_hit;
   logic        s1_hit;
   logic [1:0]  sel_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= GNT_M0;
      end else begin
         state <= state_nxt;
      end
   end

   // The holder keeps the bus while its req stays high; idle bus parks on M0.
   always_comb begin
      state_nxt = state;
      case (state)
         GNT_M0:  if (!M0_req && M1_req) state_nxt = GNT_M1;
         GNT_M1:  if (!M1_req) state_nxt = GNT_M0;
         default: state_nxt = GNT_M0;
      endcase
   end

   assign M0_grant = (state == GNT_M0);
   assign M1_grant = (state == GNT_M1);

   always_comb begin
      req_g     = M0_req;
      S_wr      = M0_wr;
      S_address = M0_address;
      S_din     = M0_dout;
      if (state == GNT_M1) begin
         req_g     = M1_req;
         S_wr      = M1_wr;
         S_address = M1_address;
         S_din     = M1_dout;
      end
   end

   // Range check as offset-from-base so a zero base never yields a constant compare.
   assign s0_off = S_address - S0_BASE;
   assign s1_off = S_address - S1_BASE;
   assign s0_hit = (s0_off <= (S0_LAST - S0_BASE));
   assign s1_hit = (s1_off <= (S1_LAST - S1_BASE));

   assign S0_sel = req_g & s0_hit;
   assign S1_sel = req_g & s1_hit & ~S0_sel;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sel_q <= 2'b00;
      end else begin
         sel_q <= {S1_sel, S0_sel};
      end
   end

   always_comb begin
      case (sel_q)
         2'b01:   M_din = S0_dout;
         2'b10:   M_din = S1_dout;
         default: M_din = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_bus_interconnect.sv
// tb/tb_bus_interconnect.sv - directed self-checking bench for bus_interconnect
module tb_bus_interconnect;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        M0_req, M0_wr, M1_req, M1_wr;
   logic [7:0]  M0_address, M1_address;
   logic [31:0] M0_dout, M1_dout;
   logic        M0_grant, M1_grant;
   logic [31:0] M_din;
   logic        S0_sel, S1_sel, S_wr;
   logic [7:0]  S_address;
   logic [31:0] S_din;
   logic [31:0] S0_dout, S1_dout;

   logic [31:0] mem [0:31];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   bus_interconnect dut (
      .clk(clk), .reset_n(reset_n),
      .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout), .M0_grant(M0_grant),
      .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout), .M1_grant(M1_grant),
      .M_din(M_din), .S0_sel(S0_sel), .S1_sel(S1_sel), .S_wr(S_wr), .S_address(S_address), .S_din(S_din),
      .S0_dout(S0_dout), .S1_dout(S1_dout)
   );

   // Slave models: read-first memory and a register file returning addr[3:0]+1, both one cycle after select.
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 + i;
         S0_dout <= 32'h0;
         S1_dout <= 32'h0;
      end else begin
         if (S0_sel) begin
            S0_dout <= mem[S_address[4:0]];
            if (S_wr) mem[S_address[4:0]] <= S_din;
         end
         if (S1_sel) S1_dout <= {28'h0, S_address[3:0]} + 32'd1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      M0_req = 0; M0_wr = 0; M0_address = 8'h00; M0_dout = 32'h0;
      M1_req = 0; M1_wr = 0; M1_address = 8'h00; M1_dout = 32'h0;
      tick; tick;
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (M0_grant !== 1'b1 || M1_grant !== 1'b0) begin
            errors++; $display("FAIL reset_grants cycle %0d: got %b%b expected 10", c, M0_grant, M1_grant);
         end
         checks++;
         if (S0_sel !== 1'b0 || S1_sel !== 1'b0 || M_din !== 32'h0) begin
            errors++; $display("FAIL reset_idle cycle %0d: sel=%b%b M_din=%h expected 00/0", c, S1_sel, S0_sel, M_din);
         end
         tick;
      end
   endtask

   task automatic test_m0_write_read;
      M0_req = 1; M0_wr = 1; M0_address = 8'h05; M0_dout = 32'hDEADBEEF;
      #1;
      checks++;
      if (S0_sel !== 1'b1 || S1_sel !== 1'b0 || S_wr !== 1'b1 || S_din !== 32'hDEADBEEF || S_address !== 8'h05) begin
         errors++; $display("FAIL m0_write: sel=%b%b wr=%b addr=%h din=%h expected 01/1/05/deadbeef", S1_sel, S0_sel, S_wr, S_address, S_din);
      end
      tick;
      M0_wr = 0;
      #1;
      checks++;
      if (S0_sel !== 1'b1 || S_wr !== 1'b0) begin
         errors++; $display("FAIL m0_read_sel: sel0=%b wr=%b expected 1/0", S0_sel, S_wr);
      end
      tick;
      checks++;
      if (M_din !== 32'hDEADBEEF) begin
         errors++; $display("FAIL m0_read_data: got %h expected deadbeef", M_din);
      end
      // Unmapped write must produce no select.
      M0_wr = 1; M0_address = 8'h20; M0_dout = 32'h1234_5678;
      #1;
      checks++;
      if (S0_sel !== 1'b0 || S1_sel !== 1'b0) begin
         errors++; $display("FAIL unmapped_write: sel=%b%b expected 00", S1_sel, S0_sel);
      end
      tick;
      M0_wr = 0; M0_req = 0;
      tick;
   endtask

   task automatic test_m1_access;
      M1_req = 1; M1_wr = 0; M1_address = 8'h72;
      #1;
      checks++;
      if (M0_grant !== 1'b1 || M1_grant !== 1'b0 || S1_sel !== 1'b0) begin
         errors++; $display("FAIL m1_pre_grant: grants=%b%b s1_sel=%b expected 10/0", M0_grant, M1_grant, S1_sel);
      end
      tick;
      checks++;
      if (M1_grant !== 1'b1 || M0_grant !== 1'b0 || S1_sel !== 1'b1 || S_address !== 8'h72) begin
         errors++; $display("FAIL m1_grant: grants=%b%b s1_sel=%b addr=%h expected 01/1/72", M0_grant, M1_grant, S1_sel, S_address);
      end
      tick;
      checks++;
      if (M_din !== 32'h0000_0003) begin
         errors++; $display("FAIL m1_read_data: got %h expected 00000003", M_din);
      end
      M1_req = 0;
      #1;
      checks++;
      if (M1_grant !== 1'b1 || S1_sel !== 1'b0) begin
         errors++; $display("FAIL m1_release_cycle: m1_grant=%b s1_sel=%b expected 1/0", M1_grant, S1_sel);
      end
      tick;
      checks++;
      if (M0_grant !== 1'b1 || M1_grant !== 1'b0) begin
         errors++; $display("FAIL m1_park: grants=%b%b expected 10", M0_grant, M1_grant);
      end
   endtask

   task automatic test_contention;
      reset_n = 0; M0_req = 1; M1_req = 1; M0_wr = 0; M1_wr = 0;
      M0_address = 8'h01; M1_address = 8'h71;
      tick;
      reset_n = 1;
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (M0_grant !== 1'b1 || M1_grant !== 1'b0) begin
            errors++; $display("FAIL contention_hold cycle %0d: grants=%b%b expected 10", c, M0_grant, M1_grant);
         end
         tick;
      end
      M0_req = 0;
      tick;
      checks++;
      if (M1_grant !== 1'b1 || M0_grant !== 1'b0 || S1_sel !== 1'b1) begin
         errors++; $display("FAIL contention_handover: grants=%b%b s1_sel=%b expected 01/1", M0_grant, M1_grant, S1_sel);
      end
      M0_req = 1;
      tick;
      checks++;
      if (M1_grant !== 1'b1) begin
         errors++; $display("FAIL no_preempt: m1_grant=%b expected 1", M1_grant);
      end
      M1_req = 0;
      tick;
      M0_req = 0;
      tick;
   endtask

   task automatic test_address_sweep;
      logic [7:0]  addrs [6] = '{8'h1F, 8'h20, 8'h6F, 8'h70, 8'h7F, 8'h80};
      logic [1:0]  sels  [6] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
      logic [31:0] datas [6] = '{32'hA500_001F, 32'h0, 32'h0, 32'h1, 32'h10, 32'h0};
      M0_req = 1; M0_wr = 0;
      for (int i = 0; i < 6; i++) begin
         M0_address = addrs[i];
         #1;
         checks++;
         if ({S1_sel, S0_sel} !== sels[i]) begin
            errors++; $display("FAIL sweep_sel addr=%h: got %b expected %b", addrs[i], {S1_sel, S0_sel}, sels[i]);
         end
         tick;
         checks++;
         if (M_din !== datas[i]) begin
            errors++; $display("FAIL sweep_data addr=%h: got %h expected %h", addrs[i], M_din, datas[i]);
         end
      end
      M0_req = 0;
      tick;
   endtask

   task automatic test_reset_mid_read;
      M1_req = 1; M1_wr = 0; M1_address = 8'h70;
      tick;
      #1;
      checks++;
      if (M1_grant !== 1'b1 || S1_sel !== 1'b1) begin
         errors++; $display("FAIL mid_setup: m1_grant=%b s1_sel=%b expected 1/1", M1_grant, S1_sel);
      end
      reset_n = 0;
      tick;
      checks++;
      if (M0_grant !== 1'b1 || M1_grant !== 1'b0 || M_din !== 32'h0) begin
         errors++; $display("FAIL mid_reset: grants=%b%b M_din=%h expected 10/0", M0_grant, M1_grant, M_din);
      end
      reset_n = 1; M1_req = 0;
      tick;
   endtask

   initial begin
      test_reset;
      test_m0_write_read;
      test_m1_access;
      test_contention;
      test_address_sweep;
      test_reset_mid_read;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_interconnect.md
# bus_interconnect

Shared 8-bit-address / 32-bit-data bus fabric: the responder side of the master bus port that the factorial accelerator's DMA master drives (`M_req`/`M_grant`/`M_wr`/`M_address`/`M_dout`/`M_din`). It arbitrates between two masters and decodes the granted master's address into two slave selects. It also returns registered-select read data to the masters. The two masters are the system/testbench master (M0) and the factorial master (M1). The two slaves are a 32-word data memory (S0) and the factorial slave register file (S1).

## Interface
- S0_BASE, 8'h00, first address of slave 0 (memory), inclusive
- S0_LAST, 8'h1F, last address of slave 0, inclusive
- S1_BASE, 8'h70, first address of slave 1 (factorial), inclusive
- S1_LAST, 8'h7F, last address of slave 1, inclusive

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- M0_req  in  1  master 0 bus request
- M0_wr  in  1  master 0 write strobe (1 = write)
- M0_address  in  8  master 0 address
- M0_dout  in  32  master 0 write data
- M0_grant  out  1  bus granted to master 0
- M1_req, M1_wr, M1_address, M1_dout  in  1/1/8/32  same for master 1
- M1_grant  out  1  bus granted to master 1
- M_din  out  32  read data broadcast to both masters
- S0_sel  out  1  slave 0 select
- S1_sel  out  1  slave 1 select
- S_wr  out  1  write strobe to slaves
- S_address  out  8  address to slaves
- S_din  out  32  write data to slaves
- S0_dout  in  32  slave 0 read data (valid the cycle after select)
- S1_dout  in  32  slave 1 read data (valid the cycle after select)

## Operation
- Arbiter FSM, 1 state bit:
  - States: GNT_M0 (reset, park state) and GNT_M1.
  - GNT_M0: if M0_req=1, stay. Else if M1_req=1, go to GNT_M1. Else stay.
  - GNT_M1: if M1_req=1, stay. Else go to GNT_M0.
  - No preemption: the holder keeps the bus while its req stays high. Masters hold req for the full transaction.
- Grants are decoded from the state register: M0_grant = (state==GNT_M0), M1_grant = (state==GNT_M1). Exactly one grant is high at all times.
- Master mux (combinational, from state): S_wr, S_address, S_din and the effective request take the granted master's wr/address/dout/req.
- Address decode (combinational):
  - S0_sel = req_g & S0_BASE ≤ S_address ≤ S0_LAST.
  - S1_sel = req_g & S1_BASE ≤ S_address ≤ S1_LAST & !S0_sel.
  - An unmapped address, or a granted master with req=0, gives both selects 0.
  - S_wr is passed through unconditionally; slaves qualify it with their sel.
- Read return: sel_q[1:0] <= {S1_sel, S0_sel} every cycle.
  - M_din = S0_dout when sel_q=01, S1_dout when sel_q=10, else 32'h0.
- A read of an unmapped address returns 32'h0. A write to an unmapped address is dropped.

## Timing
- Reset (reset_n=0 at an edge):
  - state→GNT_M0, sel_q→00.
  - Outputs: M0_grant=1, M1_grant=0, M_din=0. S0_sel/S1_sel/S_wr/S_address/S_din follow M0 inputs, gated by M0_req.
- Reset mid-transaction: M1 loses the grant at that edge. Any pending read data is discarded (M_din=0 the next cycle).
- Grant latency: M1_req rising in cycle t with M0 idle → M1_grant=1 in cycle t+1, and M1's first bus access is in t+1.
- Release: holder drops req in cycle t → the grant moves (or parks on M0) at the t+1 edge. M0 regains the bus one cycle after M1 drops req.
- Simultaneous M0_req=M1_req=1:
  - In GNT_M0: M0 keeps the bus.
  - In GNT_M1: M1 keeps the bus until it releases.
- Write: completes in the cycle where sel=1 and S_wr=1. One write per cycle is allowed, back-to-back.
- Read: address/sel in cycle t → data on M_din in cycle t+1. Back-to-back reads are pipelined at one per cycle.
- After a grant change, M_din in the first cycle still reflects the previous holder's last read. Masters ignore M_din until one cycle after their own read.
- Boundary addresses: 8'h1F maps to S0, 8'h20 is unmapped, 8'h6F is unmapped, 8'h70 and 8'h7F map to S1, 8'h80 is unmapped.

## Test plan
- Reset, all reqs 0 → M0_grant=1, M1_grant=0, S0_sel=S1_sel=0, M_din=0. Hold for 3 cycles with no change.
- M0_req=1, write 32'hDEADBEEF to 8'h05, then read 8'h05 → S0_sel=1 with S_wr=1 in the write cycle. Model-memory S0_dout returns 32'hDEADBEEF on M_din exactly one cycle after the read address.
- M0_req=0, M1_req=1 → M1_grant=1 next cycle. M1 reads 8'h72 and M_din = S1_dout (32'h0000_0003) one cycle later. M1_req drops → M0_grant=1 the following cycle.
- Both reqs 1 from reset → M0 holds the bus for 10 cycles. M0_req drops at cycle 10 → M1_grant=1 at cycle 11.
- Address sweep 8'h1F/8'h20/8'h6F/8'h70/8'h7F/8'h80 with reads → selects S0/none/none/S1/S1/none. M_din = S0_dout/0/0/S1_dout/S1_dout/0.
- M1 holding the bus with a read at 8'h70 in flight, reset_n=0 for one cycle → next cycle M0_grant=1, M1_grant=0, M_din=0.
